adc_scanner: RTL and testbench
==============================

# adc_scanner

Round-robin scan controller for the I2C-attached ADC driver on the C10LP EVK. It sequences conversions over `NUM_CH` ADC channels through the single shared `adc` driver and stores the latest 12-bit result per channel. Each stored result passes through a hysteresis threshold that produces a per-channel "above" flag for dispenser sensing logic. A watchdog flags a hung driver. The block sits between the `adc` driver instance and the dispenser control logic, in the `clk_100k` domain.

## Interface
- `NUM_CH`, 4: number of channels scanned (1..8).
- `BASE_REG0`, 8'h00: base register of channel 0; channel `c` uses `BASE_REG0 + 2*c` (8-bit, even).
- `SCAN_GAP`, 16: idle cycles between conversions (≥1).
- `TIMEOUT`, 4096: maximum WAIT cycles before a conversion is abandoned (≥2).

Ports:
- `clk_100k` in 1: block clock, same clock as the `adc` driver.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; scanning runs while high.
- `adc_req` out 1: one-cycle conversion request to the driver.
- `adc_base_reg` out 8: register address for the driver.
- `adc_done` in 1: driver completion pulse; `adc_val` is valid in the same cycle.
- `adc_val` in 12: driver result.
- `thresh_hi` in 12: set threshold, unsigned.
- `thresh_lo` in 12: clear threshold, unsigned.
- `clr_err` in 1: clears `timeout_err`.
- `sample` out 12*NUM_CH: latest result; channel `c` occupies `[12c+11:12c]`.
- `sample_valid` out NUM_CH: bit `c` = `sample[c]` holds a completed conversion.
- `above` out NUM_CH: hysteresis flag per channel.
- `scan_done` out 1: one-cycle pulse at the end of each full round.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Registers: state, channel index `ch` (0..NUM_CH-1), gap counter, watchdog counter.
- Reset values: state IDLE, `ch`=0, `adc_req`=0, `adc_base_reg`=BASE_REG0, `sample`=0, `sample_valid`=0, `above`=0, `scan_done`=0, `timeout_err`=0.
- States and transitions:
  - **IDLE**: if `enable` → REQ.
  - **REQ**: `adc_req`=1 for this cycle only; `adc_base_reg` = BASE_REG0+2*ch. Clear watchdog; → WAIT.
  - **WAIT**:
    - If `adc_done`: capture `adc_val` into `sample[ch]`, set `sample_valid[ch]`, update `above[ch]`, then → GAP.
    - Else if watchdog = TIMEOUT-1: set `timeout_err`, clear `sample_valid[ch]` (leave `sample[ch]` unchanged), then → GAP.
    - Else: increment watchdog.
  - **GAP**: count SCAN_GAP cycles. On the last cycle:
    - `ch` ← `ch`+1, or 0 if `ch`=NUM_CH-1. A wrap pulses `scan_done`.
    - Then → REQ if `enable`, else → IDLE.
- Hysteresis:
  - If `adc_val` ≥ `thresh_hi`: `above` ← 1.
  - Else if `adc_val` < `thresh_lo`: `above` ← 0.
  - Else: hold.
  - Set takes priority, so it also applies if `thresh_lo` > `thresh_hi`.
- `enable` is sampled only in IDLE and at GAP exit. Deasserting it mid-conversion lets the conversion and its gap complete. `ch` is retained, so a re-enable resumes at the next channel.
- `adc_done` outside WAIT is ignored; no state changes.
- A late `adc_done` after a timeout that arrives during a later WAIT is attributed to the current channel. A timeout means the driver is considered hung, so this is accepted behaviour.
- `clr_err` clears `timeout_err`. If a new timeout occurs in the same cycle, set wins.
- Thresholds are sampled on the `adc_done` cycle only.

## Timing
- `enable` high at edge k in IDLE → `adc_req` high during cycle k+1 (one cycle) → WAIT from k+2.
- `adc_base_reg` changes only on entry to REQ. It is stable from REQ through the end of WAIT.
- `adc_done` sampled at edge d → `sample`, `sample_valid`, `above` updated at d+1; GAP lasts cycles d+1..d+SCAN_GAP. The next `adc_req` is in cycle d+SCAN_GAP+1.
- Per-channel period = 1 + W + SCAN_GAP cycles, where W is the number of WAIT cycles up to and including the `adc_done` cycle.
- On timeout, WAIT lasts exactly TIMEOUT cycles. `timeout_err` becomes visible the following cycle.
- `scan_done` is high in the single cycle following the last GAP cycle of channel NUM_CH-1.
- `rst` asserts all outputs to their reset values immediately, without a clock edge, from any state including mid-WAIT.

## Test plan
- **Basic scan**: reset, `enable`=1, NUM_CH=4. Model answers 40 cycles after `adc_req` with `adc_val`=0x100*ch+0x23. Required: `adc_base_reg` 0x00,0x02,0x04,0x06; `sample` = 0x023,0x123,0x223,0x323; `sample_valid`=4'hF; one `scan_done` pulse; consecutive `adc_req` spacing = 1+40+16 cycles.
- **Hysteresis**: `thresh_hi`=0x800, `thresh_lo`=0x700, ch0 values 0x7FF,0x800,0x750,0x6FF → `above[0]` 0,1,1,0. With `thresh_lo`=0x900 and value 0x850 → `above[0]`=1.
- **Timeout**: model never answers ch2 → `timeout_err`=1 exactly TIMEOUT cycles after the WAIT entry; `sample_valid[2]`=0; next `adc_base_reg`=0x06. `clr_err` clears the flag; `clr_err` coincident with a new timeout leaves it at 1.
- **Enable drop**: drop `enable` during ch1 WAIT → ch1 result stored, no further `adc_req` after GAP. Re-enable → `adc_base_reg`=0x04.
- **Async reset**: assert `rst` mid-WAIT between clock edges → all outputs at reset values before the next edge. An `adc_done` pulse after release with `enable`=0 → no change.
- **Stray done**: `adc_done` pulses during IDLE and GAP with `adc_val`=0xFFF → `sample`, `sample_valid`, `above` unchanged.

Source files
------------

// File: rtl/adc_scanner.sv
// adc_scanner: round-robin conversion sequencer for a shared ADC driver.
// Issues one request per channel, stores the latest 12-bit result per
// channel with a hysteresis "above" flag, and raises a sticky watchdog
// flag when the driver fails to answer within TIMEOUT wait cycles.
//
// Ports:
//   clk_100k, rst        block clock, async active-high reset
//   enable               scanning runs while high (sampled in IDLE / at GAP exit)
//   adc_req/adc_base_reg request pulse and register address to the driver
//   adc_done/adc_val     driver completion pulse and result
//   thresh_hi/thresh_lo  hysteresis set / clear thresholds
//   clr_err              clears timeout_err
//   sample/sample_valid  per-channel latest result and its validity
//   above                per-channel hysteresis flag
//   scan_done            one-cycle pulse after each full round
//   timeout_err          sticky watchdog flag
//
// state | meaning
// IDLE  | waiting for enable
// REQ   | one-cycle request to the driver
// WAIT  | waiting for adc_done, watchdog running
// GAP   | SCAN_GAP idle cycles before the next channel
module adc_scanner #(
  parameter int          NUM_CH    = 4,
  parameter logic [7:0]  BASE_REG0 = 8'h00,
  parameter int          SCAN_GAP  = 16,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                   clk_100k,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   adc_req,
  output logic [7:0]             adc_base_reg,
  input  logic                   adc_done,
  input  logic [11:0]            adc_val,
  input  logic [11:0]            thresh_hi,
  input  logic [11:0]            thresh_lo,
  input  logic                   clr_err,
  output logic [12*NUM_CH-1:0]   sample,
  output logic [NUM_CH-1:0]      sample_valid,
  output logic [NUM_CH-1:0]      above,
  output logic                   scan_done,
  output logic                   timeout_err
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW = $clog2(SCAN_GAP + 1);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(SCAN_GAP - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] ch, ch_next;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic          capture, timeout, gap_exit, wrap;

  always_ff @(posedge clk_100k or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ch_next    = ch;
    capture    = 1'b0;
    timeout    = 1'b0;
    gap_exit   = 1'b0;
    wrap       = 1'b0;
    unique case (state)
      IDLE: if (enable) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: begin
        if (adc_done) begin
          capture    = 1'b1;
          state_next = GAP;
        end else if (wd_cnt == WD_LAST) begin
          timeout    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        // gap counter is a down-counter; zero marks the last GAP cycle
        if (gap_cnt == '0) begin
          gap_exit   = 1'b1;
          wrap       = (ch == CH_LAST);
          ch_next    = wrap ? '0 : ch + 1'b1;
          state_next = enable ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100k or posedge rst) begin
    if (rst) begin
      ch           <= '0;
      gap_cnt      <= '0;
      wd_cnt       <= '0;
      adc_req      <= 1'b0;
      adc_base_reg <= BASE_REG0;
      sample       <= '0;
      sample_valid <= '0;
      above        <= '0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      ch        <= ch_next;
      adc_req   <= (state_next == REQ);
      scan_done <= gap_exit && wrap;

      // address only moves on REQ entry, so it is stable through WAIT
      if (state_next == REQ)
        adc_base_reg <= BASE_REG0 + 8'({ch_next, 1'b0});

      if (state == REQ)
        wd_cnt <= '0;
      else if (state == WAIT && !capture && !timeout)
        wd_cnt <= wd_cnt + 1'b1;

      if (capture || timeout)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      if (capture) begin
        sample[12*int'(ch) +: 12] <= adc_val;
        sample_valid[ch]          <= 1'b1;
        // set is checked first so it wins when thresh_lo > thresh_hi
        if (adc_val >= thresh_hi)
          above[ch] <= 1'b1;
        else if (adc_val < thresh_lo)
          above[ch] <= 1'b0;
      end

      if (timeout)
        sample_valid[ch] <= 1'b0;

      if (timeout)
        timeout_err <= 1'b1;
      else if (clr_err)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scanner.sv
// tb_adc_scanner: directed + randomized bench for adc_scanner, with a
// behavioural per-channel reference model kept in plain arrays.
module tb_adc_scanner;

  localparam int         NUM_CH    = 4;
  localparam logic [7:0] BASE_REG0 = 8'h00;
  localparam int         SCAN_GAP  = 16;
  localparam int         TIMEOUT   = 4096;

  logic                 clk_100k = 1'b0;
  logic                 rst, enable, adc_req, adc_done, clr_err;
  logic                 scan_done, timeout_err;
  logic [7:0]           adc_base_reg;
  logic [11:0]          adc_val, thresh_hi, thresh_lo;
  logic [12*NUM_CH-1:0] sample;
  logic [NUM_CH-1:0]    sample_valid, above;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int sd_cnt = 0;

  adc_scanner #(
    .NUM_CH(NUM_CH), .BASE_REG0(BASE_REG0), .SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_100k(clk_100k), .rst(rst), .enable(enable),
    .adc_req(adc_req), .adc_base_reg(adc_base_reg),
    .adc_done(adc_done), .adc_val(adc_val),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .clr_err(clr_err),
    .sample(sample), .sample_valid(sample_valid), .above(above),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk_100k = ~clk_100k;
  always @(posedge clk_100k) cyc <= cyc + 1;
  always @(negedge clk_100k) if (scan_done === 1'b1) sd_cnt++;

  // reference model
  logic [11:0] m_sample [NUM_CH];
  bit          m_valid  [NUM_CH];
  bit          m_above  [NUM_CH];
  int          m_ch;
  bit          m_err;
  bit          m_sd;
  int          m_period;
  int          last_req;

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sample[c] = '0;
      m_valid[c]  = 1'b0;
      m_above[c]  = 1'b0;
    end
    m_ch = 0; m_err = 1'b0; m_sd = 1'b0; m_period = -1;
  endfunction

  function automatic bit hyst(bit prev, int v, int hi, int lo);
    if (v >= hi) return 1'b1;
    if (v < lo)  return 1'b0;
    return prev;
  endfunction

  function automatic logic [12*NUM_CH-1:0] m_sample_vec();
    logic [12*NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[12*c +: 12] = m_sample[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_valid_vec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_valid[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_above_vec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_above[c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_100k);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sample"}, sample, m_sample_vec());
    check({tag, "_valid"}, sample_valid, m_valid_vec());
    check({tag, "_above"}, above, m_above_vec());
    check({tag, "_err"}, timeout_err, m_err);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, adc_req, 1'b0);
    check({tag, "_base"}, adc_base_reg, BASE_REG0);
    check({tag, "_sample"}, sample, '0);
    check({tag, "_valid"}, sample_valid, '0);
    check({tag, "_above"}, above, '0);
    check({tag, "_scan_done"}, scan_done, 1'b0);
    check({tag, "_err"}, timeout_err, 1'b0);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (adc_req !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("req_seen", adc_req, 1'b1);
    check("base_reg", adc_base_reg, BASE_REG0 + 8'(2 * m_ch));
    check("scan_done_at_req", scan_done, m_sd);
    if (m_period > 0) check("req_spacing", cyc - last_req, m_period);
    last_req = cyc;
    m_sd = 1'b0;
  endtask

  task automatic advance_ch(input int period);
    m_sd     = (m_ch == NUM_CH - 1);
    m_ch     = (m_ch + 1) % NUM_CH;
    m_period = period;
  endtask

  // one answered conversion: the driver replies on WAIT cycle 'lat'
  task automatic conv(input logic [11:0] val, input int lat, input bit drop_en);
    wait_req();
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (drop_en && i == 1) enable = 1'b0;
    end
    adc_val  = val;
    adc_done = 1'b1;
    m_sample[m_ch] = val;
    m_valid[m_ch]  = 1'b1;
    m_above[m_ch]  = hyst(m_above[m_ch], val, thresh_hi, thresh_lo);
    tick();
    adc_done = 1'b0;
    adc_val  = 12'($urandom);
    check_outputs("conv");
    advance_ch(1 + lat + SCAN_GAP);
  endtask

  // unanswered conversion; optionally pulse clr_err on the timeout cycle
  task automatic timeout_conv(input bit clr_coincide);
    wait_req();
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i == TIMEOUT) begin
        check("err_before_timeout", timeout_err, m_err);
        if (clr_coincide) clr_err = 1'b1;
      end
    end
    tick();
    clr_err = 1'b0;
    m_err = 1'b1;
    m_valid[m_ch] = 1'b0;
    check_outputs("timeout");
    advance_ch(1 + TIMEOUT + SCAN_GAP);
  endtask

  logic [11:0] hv [4] = '{12'h7FF, 12'h800, 12'h750, 12'h6FF};
  bit          ha [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int en_c, req_cnt;
    rst = 1'b1; enable = 1'b0; adc_done = 1'b0; adc_val = '0; clr_err = 1'b0;
    thresh_hi = 12'h800; thresh_lo = 12'h700;
    m_reset();
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // basic scan
    enable = 1'b1;
    for (int c = 0; c < NUM_CH; c++) conv(12'(32'h100 * c + 32'h23), 40, 1'b0);
    check("basic_sample", sample, 48'h323_223_123_023);
    check("basic_valid", sample_valid, 4'hF);

    // hysteresis on channel 0, random data on the others
    for (int r = 0; r < 5; r++) begin
      if (r == 4) thresh_lo = 12'h900;
      conv((r == 4) ? 12'h850 : hv[r], $urandom_range(1, 50), 1'b0);
      check("hyst_above0", above[0], (r == 4) ? 1'b1 : ha[r]);
      if (r == 0) check("scan_done_count", sd_cnt, 1);
      for (int c = 1; c < NUM_CH; c++) conv(12'($urandom), $urandom_range(1, 50), 1'b0);
    end

    // randomized values, thresholds and latencies
    for (int k = 0; k < 8; k++) begin
      thresh_hi = 12'($urandom);
      thresh_lo = 12'($urandom);
      conv(12'($urandom), $urandom_range(1, 60), 1'b0);
    end

    // timeout on channel 2, then clear
    thresh_hi = 12'h800; thresh_lo = 12'h700;
    while (m_ch != 2) conv(12'($urandom), $urandom_range(1, 30), 1'b0);
    timeout_conv(1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err = 1'b0;
    check("clr_err", timeout_err, 1'b0);
    while (m_ch != 2) conv(12'($urandom), $urandom_range(1, 30), 1'b0);
    timeout_conv(1'b1);
    tick();
    check("err_sticky", timeout_err, 1'b1);

    // enable drop during channel 1 WAIT
    while (m_ch != 1) conv(12'($urandom), $urandom_range(1, 30), 1'b0);
    conv(12'($urandom), $urandom_range(5, 30), 1'b1);
    req_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (adc_req === 1'b1) req_cnt++;
    end
    check("no_req_after_drop", req_cnt, 0);
    check_outputs("idle");
    m_sd = 1'b0; m_period = -1;
    en_c = cyc;
    enable = 1'b1;
    conv(12'($urandom), $urandom_range(1, 30), 1'b0);
    check("reenable_latency", last_req - en_c, 1);

    // async reset mid-WAIT, error flag and samples non-zero beforehand
    wait_req();
    tick();
    tick();
    #3;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    m_reset();
    check_reset("async_reset");
    tick();
    rst = 1'b0;
    tick();
    adc_val = 12'hFFF;
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    tick();
    check_outputs("stray_idle");
    check("stray_idle_req", adc_req, 1'b0);

    // stray done during GAP
    thresh_hi = 12'h800; thresh_lo = 12'h700;
    enable = 1'b1;
    conv(12'($urandom_range(0, 12'h6FF)), $urandom_range(1, 30), 1'b0);
    tick();
    adc_val = 12'hFFF;
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    tick();
    check_outputs("stray_gap");
    conv(12'($urandom), $urandom_range(1, 30), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
